// File: rtl/ex_wb_pipe.sv
// Execute-to-writeback stage: captures ALU results into a 2-entry FIFO skid buffer
// and turns taken conditional branches into a one-cycle fetch redirect pulse.
module ex_wb_pipe #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  is_branch,
  input  logic                  branch_on_zero,
  input  logic [DATA_W-1:0]     branch_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  redirect_valid,
  output logic [DATA_W-1:0]     redirect_target,
  output logic [1:0]            occupancy
);

  logic                  main_valid, skid_valid;
  logic [DATA_W-1:0]     main_result, skid_result;
  logic [REG_ADDR_W-1:0] main_rd, skid_rd;
  logic                  main_we, skid_we;

  logic accept, drain, taken, cap_we;
  logic main_valid_nxt, skid_valid_nxt;
  logic load_main_from_skid, load_main_from_in, load_skid_from_in;

  assign out_valid     = main_valid;
  assign out_result    = main_result;
  assign out_rd        = main_rd;
  assign out_reg_write = main_we;

  // in_ready is a register, so an accept never coincides with a full skid slot;
  // that is what keeps a drain+accept from ever needing three slots.
  always_comb begin
    accept = in_valid && in_ready && !flush;
    drain  = main_valid && out_ready;
    taken  = is_branch && (alu_zero == branch_on_zero);
    cap_we = reg_write && (rd_addr != '0);

    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    if (drain) begin
      main_valid_nxt = skid_valid || accept;
      skid_valid_nxt = 1'b0;
    end else if (accept) begin
      if (main_valid) skid_valid_nxt = 1'b1;
      else            main_valid_nxt = 1'b1;
    end

    load_main_from_skid = drain && skid_valid;
    load_main_from_in   = accept && (!main_valid || drain);
    load_skid_from_in   = accept && main_valid && !drain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid      <= 1'b0;
      skid_valid      <= 1'b0;
      main_result     <= '0;
      main_rd         <= '0;
      main_we         <= 1'b0;
      skid_result     <= '0;
      skid_rd         <= '0;
      skid_we         <= 1'b0;
      in_ready        <= 1'b1;
      occupancy       <= 2'd0;
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
    end else if (flush) begin
      main_valid     <= 1'b0;
      skid_valid     <= 1'b0;
      in_ready       <= 1'b1;
      occupancy      <= 2'd0;
      redirect_valid <= 1'b0;
    end else begin
      main_valid     <= main_valid_nxt;
      skid_valid     <= skid_valid_nxt;
      in_ready       <= !skid_valid_nxt;
      occupancy      <= {1'b0, main_valid_nxt} + {1'b0, skid_valid_nxt};
      redirect_valid <= accept && taken;
      if (accept && taken) redirect_target <= branch_target;

      if (load_main_from_skid) begin
        main_result <= skid_result;
        main_rd     <= skid_rd;
        main_we     <= skid_we;
      end else if (load_main_from_in) begin
        main_result <= alu_result;
        main_rd     <= rd_addr;
        main_we     <= cap_we;
      end

      if (load_skid_from_in) begin
        skid_result <= alu_result;
        skid_rd     <= rd_addr;
        skid_we     <= cap_we;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Bench for ex_wb_pipe: directed scenarios then random traffic, all checked
// against a queue-based model of the stage's FIFO and redirect behaviour.
module tb_ex_wb_pipe;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst, flush, in_valid, in_ready;
  logic [DATA_W-1:0]     alu_result, branch_target;
  logic                  alu_zero, reg_write, is_branch, branch_on_zero;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  out_valid, out_ready, out_reg_write, redirect_valid;
  logic [DATA_W-1:0]     out_result, redirect_target;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [1:0]            occupancy;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [DATA_W-1:0]     res;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
  } entry_t;

  entry_t            m_q[$];
  logic              m_rv = 1'b0;
  logic [DATA_W-1:0] m_rt = '0;

  always #5 clk = ~clk;

  ex_wb_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .rd_addr(rd_addr),
    .reg_write(reg_write), .is_branch(is_branch), .branch_on_zero(branch_on_zero),
    .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .occupancy(occupancy)
  );

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: an ordered list of held entries with capacity two; the stage
  // accepts only when it held fewer than two entries at the end of last cycle.
  task automatic modelUpdate(input logic v, input logic [DATA_W-1:0] res, input logic zero,
                             input logic [REG_ADDR_W-1:0] rd, input logic rw, input logic br,
                             input logic boz, input logic [DATA_W-1:0] tgt,
                             input logic ordy, input logic fl, input logic rs);
    entry_t e;
    logic acc, tk;
    acc = v && (m_q.size() < 2) && !fl;
    tk  = br && (zero == boz);
    if (rs) begin
      m_q.delete();
      m_rv = 1'b0;
      m_rt = '0;
    end else if (fl) begin
      m_q.delete();
      m_rv = 1'b0;
    end else begin
      if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
      if (acc) begin
        e.res = res;
        e.rd  = rd;
        e.we  = rw && (rd != 0);
        m_q.push_back(e);
      end
      m_rv = acc && tk;
      if (acc && tk) m_rt = tgt;
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() > 0});
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, m_q.size() < 2});
    checkOutput("occupancy", {62'd0, occupancy}, 64'(m_q.size()));
    checkOutput("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
    checkOutput("redirect_target", redirect_target, m_rt);
    if (m_q.size() > 0) begin
      checkOutput("out_result", out_result, m_q[0].res);
      checkOutput("out_rd", {59'd0, out_rd}, {59'd0, m_q[0].rd});
      checkOutput("out_reg_write", {63'd0, out_reg_write}, {63'd0, m_q[0].we});
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then compare.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] res, input logic zero,
                               input logic [REG_ADDR_W-1:0] rd, input logic rw, input logic br,
                               input logic boz, input logic [DATA_W-1:0] tgt,
                               input logic ordy, input logic fl, input logic rs);
    in_valid = v; alu_result = res; alu_zero = zero; rd_addr = rd; reg_write = rw;
    is_branch = br; branch_on_zero = boz; branch_target = tgt;
    out_ready = ordy; flush = fl; rst = rs;
    @(posedge clk);
    modelUpdate(v, res, zero, rd, rw, br, boz, tgt, ordy, fl, rs);
    #1;
    compareAll();
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_out_result", out_result, 64'd0);
    checkOutput("reset_out_rd", {59'd0, out_rd}, 64'd0);
    checkOutput("reset_out_reg_write", {63'd0, out_reg_write}, 64'd0);

    // Pass-through
    applyStimulus(1'b1, 64'h5, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("pass_result", out_result, 64'h5);
    checkOutput("pass_occupancy", {62'd0, occupancy}, 64'd1);
    idle(1'b1);

    // Backpressure: A, B held, C refused until a slot frees
    applyStimulus(1'b1, 64'hA, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hB, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hC, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_full_head", out_result, 64'hA);
    applyStimulus(1'b1, 64'hC, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_second", out_result, 64'hB);
    applyStimulus(1'b1, 64'hC, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_third", out_result, 64'hC);
    idle(1'b1);
    idle(1'b1);

    // Write to x0 is suppressed
    applyStimulus(1'b1, 64'h77, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("x0_write", {63'd0, out_reg_write}, 64'd0);
    idle(1'b1);

    // Branch taken then not taken
    applyStimulus(1'b1, 64'h0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 64'h1000, 1'b1, 1'b0, 1'b0);
    checkOutput("br_taken_pulse", {63'd0, redirect_valid}, 64'd1);
    checkOutput("br_taken_target", redirect_target, 64'h1000);
    applyStimulus(1'b1, 64'h1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 64'h2000, 1'b1, 1'b0, 1'b0);
    checkOutput("br_not_taken", {63'd0, redirect_valid}, 64'd0);
    checkOutput("br_target_held", redirect_target, 64'h1000);
    idle(1'b1);

    // Flush while full with a taken branch offered
    applyStimulus(1'b1, 64'h11, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h12, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 64'h3000, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_occupancy", {62'd0, occupancy}, 64'd0);
    checkOutput("flush_redirect", {63'd0, redirect_valid}, 64'd0);

    // A registered redirect pulse survives a flush on the following cycle
    applyStimulus(1'b1, 64'h0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 64'h4000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; flush = 1'b1;
    checkOutput("pulse_before_flush", {63'd0, redirect_valid}, 64'd1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream while full
    applyStimulus(1'b1, 64'h21, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 64'h5000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h23, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_mid_redirect_target", redirect_target, 64'd0);
    checkOutput("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 4) != 0,
                    {32'($urandom), 32'($urandom)},
                    1'($urandom),
                    5'($urandom_range(0, 31)),
                    1'($urandom),
                    ($urandom % 3) == 0,
                    1'($urandom),
                    {32'($urandom), 32'($urandom)},
                    ($urandom % 3) != 0,
                    ($urandom % 20) == 0,
                    ($urandom % 80) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
